// File: rtl/bit_serial_tx_if.sv
// Load handshake between a word source and bit_serial_tx.
// master = word source, slave = transmitter.
interface bit_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/bit_serial_tx.sv
// Parallel-to-serial transmitter: one bit per clock on ser_out, strobed by ser_en.
// Define BIT_SERIAL_TX_PARITY_EN to append an even-parity bit after each word.
module bit_serial_tx #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  bit_serial_tx_if.slave bus,
  output logic           ser_out,
  output logic           ser_en,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [7:0]    GAP_LAST = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

`ifdef BIT_SERIAL_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_adv;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_en_q, ser_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             end_word;
`ifdef BIT_SERIAL_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // The bit presented next always sits at the leading end of the register.
  function automatic logic lead_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  assign shift_adv      = advance(shift_q);
  assign bus.load_ready = (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ser_out_d = 1'b0;
    ser_en_d  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    end_word  = 1'b0;
`ifdef BIT_SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          state_d   = SHIFT;
          shift_d   = bus.data_in;
          bit_cnt_d = '0;
          ser_en_d  = 1'b1;
          ser_out_d = lead_bit(bus.data_in);
          busy_d    = 1'b1;
`ifdef BIT_SERIAL_TX_PARITY_EN
          parity_d  = ^bus.data_in;
`endif
        end
      end

      SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
`ifdef BIT_SERIAL_TX_PARITY_EN
          state_d   = PARITY;
          ser_en_d  = 1'b1;
          ser_out_d = parity_q;
`else
          end_word  = 1'b1;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          shift_d   = shift_adv;
          ser_en_d  = 1'b1;
          ser_out_d = lead_bit(shift_adv);
        end
      end

`ifdef BIT_SERIAL_TX_PARITY_EN
      PARITY: begin
        end_word = 1'b1;
      end
`endif

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // done coincides with the first gap cycle, or with the return to IDLE when there is no gap.
    if (end_word) begin
      done_d = 1'b1;
      if (GAP_CYCLES > 0) begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end else begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ser_out_q <= 1'b0;
      ser_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BIT_SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ser_out_q <= ser_out_d;
      ser_en_q  <= ser_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BIT_SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign ser_out = ser_out_q;
  assign ser_en  = ser_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bit_serial_tx.sv
// Scoreboard bench for bit_serial_tx: several parameter sets side by side, each with a
// driver pushing accepted words and a monitor checking every cycle against the word's timeline.
module tb_bit_serial_tx;

`ifdef BIT_SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NI = 5;
  localparam int NW = 30;

  typedef struct {
    logic [31:0] word;
    int          acc;
  } rec_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_fin = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0h, expected %0h (cycle %0d)", nm, inst, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pick_word(input int n);
    case (n)
      0: return 32'hA5;
      1: return 32'h03;
      2: return 32'h0F;
      3: return 32'hF0;
      4: return 32'h07;
      5: return 32'h03;
      default: return $urandom;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_inst
      localparam int W = (gi == 1) ? 1 : (gi == 3) ? 5 : (gi == 4) ? 32 : 8;
      localparam int M = (gi == 1 || gi == 2 || gi == 4) ? 0 : 1;
      localparam int G = (gi == 0) ? 1 : (gi == 2) ? 3 : (gi == 3) ? 2 : 0;
      localparam int NB = W + PAR;
      localparam logic [31:0] MASK = (W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << W) - 32'd1);

      logic rst_n;
      logic ser_out, ser_en, busy, done;
      rec_t q[$];

      bit_serial_tx_if #(.WIDTH(W)) bus_i ();

      bit_serial_tx #(
        .WIDTH(W),
        .MSB_FIRST(M),
        .GAP_CYCLES(G)
      ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus_i),
        .ser_out(ser_out),
        .ser_en (ser_en),
        .busy   (busy),
        .done   (done)
      );

      // Driver: present a word, wait (bounded) for ready, and log it at the acceptance edge.
      initial begin : drv
        logic [31:0] wd;
        rec_t        r;
        int          t;
        int          idle;
        rst_n = 1'b1;
        bus_i.load_valid = 1'b0;
        bus_i.data_in = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        for (int n = 0; n < NW + 1; n++) begin
          wd = (n == NW) ? 32'hFF : (pick_word(n) & MASK);
          wd = wd & MASK;
          bus_i.data_in = wd[W-1:0];
          bus_i.load_valid = 1'b1;
          t = 0;
          while (!bus_i.load_ready && t < 300) begin
            @(negedge clk);
            t++;
          end
          check("ready_wait", gi, {31'd0, bus_i.load_ready}, 32'd1);
          if (bus_i.load_ready) begin
            r.word = wd;
            r.acc  = cyc;
            q.push_back(r);
            n_vec++;
            $display("inst%0d: word %h accepted at cycle %0d", gi, wd, cyc + 1);
          end
          @(negedge clk);
          if (n == NW) break;
          idle = (n == 2) ? 0 : (n < 6) ? 1 : int'($urandom_range(0, 2));
          if (idle > 0) begin
            bus_i.load_valid = 1'b0;
            wd = $urandom;
            bus_i.data_in = wd[W-1:0];
            repeat (idle) @(negedge clk);
          end
        end

        // The 0xFF word above is in flight: abort it at cycle 4 with an asynchronous reset.
        bus_i.load_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ser_en", gi, {31'd0, ser_en}, 32'd0);
        check("rst_ser_out", gi, {31'd0, ser_out}, 32'd0);
        check("rst_busy", gi, {31'd0, busy}, 32'd0);
        check("rst_done", gi, {31'd0, done}, 32'd0);
        wd = 32'h81 & MASK;
        bus_i.data_in = wd[W-1:0];
        bus_i.load_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        check("ready_after_rst", gi, {31'd0, bus_i.load_ready}, 32'd1);
        r.word = wd;
        r.acc  = cyc;
        q.push_back(r);
        n_vec++;
        $display("inst%0d: word %h accepted at cycle %0d", gi, wd, cyc + 1);
        @(negedge clk);
        bus_i.load_valid = 1'b0;
        repeat (NB + G + 6) @(negedge clk);
        check("queue_drained", gi, q.size(), 32'd0);
        n_fin++;
      end

      // Monitor: every falling edge, compare all outputs with the head word's timeline.
      rec_t cur;
      bit   have = 1'b0;
      int   p;
      initial begin : mon
        logic e_en, e_out, e_done, e_busy, e_rdy;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            have = 1'b0;
            q.delete();
            check("reset_ser_en", gi, {31'd0, ser_en}, 32'd0);
            check("reset_ser_out", gi, {31'd0, ser_out}, 32'd0);
            check("reset_busy", gi, {31'd0, busy}, 32'd0);
            check("reset_done", gi, {31'd0, done}, 32'd0);
            check("reset_ready", gi, {31'd0, bus_i.load_ready}, 32'd1);
          end else begin
            if (!have && q.size() > 0 && cyc > q[0].acc) begin
              cur = q.pop_front();
              have = 1'b1;
            end
            if (have) begin
              p      = cyc - cur.acc;
              e_en   = (p >= 1 && p <= NB);
              e_out  = 1'b0;
              if (p >= 1 && p <= W)
                e_out = (M != 0) ? cur.word[W - p] : cur.word[p - 1];
              else if (p == W + 1 && PAR == 1)
                e_out = ^cur.word;
              e_done = (p == NB + 1);
              e_busy = (p <= NB + G);
              e_rdy  = (p >= NB + G + 1);
              check("ser_en", gi, {31'd0, ser_en}, {31'd0, e_en});
              check("ser_out", gi, {31'd0, ser_out}, {31'd0, e_out});
              check("done", gi, {31'd0, done}, {31'd0, e_done});
              check("busy", gi, {31'd0, busy}, {31'd0, e_busy});
              check("load_ready", gi, {31'd0, bus_i.load_ready}, {31'd0, e_rdy});
              if (p >= NB + G + 1) have = 1'b0;
            end else begin
              check("idle_ser_en", gi, {31'd0, ser_en}, 32'd0);
              check("idle_ser_out", gi, {31'd0, ser_out}, 32'd0);
              check("idle_done", gi, {31'd0, done}, 32'd0);
              check("idle_busy", gi, {31'd0, busy}, 32'd0);
              check("idle_ready", gi, {31'd0, bus_i.load_ready}, 32'd1);
            end
          end
        end
      end
    end
  endgenerate

  initial begin : main
    for (int i = 0; i < 60000 && n_fin < NI; i++) @(negedge clk);
    if (n_fin < NI) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_timeout: got %0d finished drivers, expected %0d", n_fin, NI);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bit_serial_tx.md
Name: bit_serial_tx

Overview:
- Transmit-side counterpart of the single-bit enabled capture register (D_in/en/D_out).
- Accepts a WIDTH-bit parallel word over a valid/ready handshake.
- Presents the word one bit per clock on ser_out, with ser_en strobing each valid bit, so a chain of enabled 1-bit registers can capture it.
- Sits between the test/stimulus logic and the 1-bit register datapath.

Parameters:
- WIDTH, 8: word length in bits; legal range 1..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
- GAP_CYCLES, 1: idle cycles inserted after each word before load_ready reasserts; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  parallel word to send.
- load_valid  input  1  data_in is valid.
- load_ready  output  1  block can accept a word.
- ser_out  output  1  serial data bit, registered.
- ser_en  output  1  ser_out is a valid bit this cycle, registered.
- busy  output  1  word in flight, including gap.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- While rst_n=0: state=IDLE, shift register=0, bit counter=0, gap counter=0, ser_out=0, ser_en=0, busy=0, done=0, load_ready=1.
- FSM states are IDLE, SHIFT, GAP (plus PARITY, see Optional Feature).
- IDLE:
  - load_ready=1 (combinational from state).
  - On a clock edge with load_valid=1, data_in is latched, state goes to SHIFT, busy=1.
  - load_valid=0 keeps the FSM in IDLE.
- SHIFT, latency and cadence:
  - ser_en=1 for exactly WIDTH consecutive cycles, starting the cycle after acceptance (cycles 1..WIDTH, acceptance edge = cycle 0).
  - ser_out carries bit order per MSB_FIRST.
  - The shift register moves one position per cycle.
  - The bit counter runs 0..WIDTH-1; it is sized clog2(WIDTH)+1 so it does not wrap.
- End of word:
  - After the last bit, done=1 for exactly one cycle (cycle WIDTH+1).
  - If GAP_CYCLES>0: state=GAP for GAP_CYCLES cycles (starting cycle WIDTH+1), ser_en=0, ser_out=0, busy=1, then IDLE.
  - If GAP_CYCLES=0: go directly to IDLE at cycle WIDTH+1, busy=0.
- ser_out=0 whenever ser_en=0.
- load_ready=0 in SHIFT, GAP and PARITY. load_valid asserted there is ignored, and no word is lost silently: the source must hold it.
- The earliest next acceptance is cycle WIDTH+1+GAP_CYCLES. Per-word throughput is WIDTH+1+GAP_CYCLES cycles.
- data_in changes after acceptance have no effect on the word in flight.
- WIDTH=1: a single ser_en cycle, then done.
- Reset mid-word: the word is aborted, ser_en/ser_out/busy go 0 asynchronously, no done pulse, and the FSM is in IDLE after release.
- Reset release with load_valid=1: the word is accepted on the first rising edge after release.

Optional Feature:
- Macro: BIT_SERIAL_TX_PARITY_EN.
- Defined: after the WIDTH data bits, one extra cycle in state PARITY with ser_en=1 and ser_out = XOR of the latched word (even parity). done and GAP shift one cycle later. Throughput is WIDTH+2+GAP_CYCLES.
- Undefined: no PARITY state, and timing is exactly as above.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, GAP=1; load 0xA5 -> ser_en=1 on cycles 1..8, ser_out=1,0,1,0,0,1,0,1; done=1 on cycle 9; load_ready=1 again on cycle 10.
2. MSB_FIRST=0; load 0x03 -> ser_out=1,1,0,0,0,0,0,0; ser_en=0 and ser_out=0 in all idle/gap cycles.
3. load_valid held high continuously with 0x0F, then 0xF0 -> two words with exactly GAP_CYCLES+1 cycles (done cycle plus gap) between the last bit of word 1 and the first bit of word 2; data_in change mid-word does not alter word 1 bits.
4. Assert rst_n=0 at cycle 4 of 0xFF -> ser_en, busy and ser_out go 0 immediately, no done; after release, load 0x81 is sent cleanly as 1,0,0,0,0,0,0,1.
5. With BIT_SERIAL_TX_PARITY_EN defined, load 0x07 -> 8 data bits, then 9th ser_en cycle with ser_out=1; done on cycle 10. Load 0x03 -> parity bit 0.
6. GAP_CYCLES=0 and WIDTH=1; load 1 then 0 back-to-back -> ser_en pattern 1,0,1 on cycles 1..3 with ser_out=1 then 0; done pulses on cycles 2 and 4.
